mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit between the multi-cycle datapath and the single-ported, word-addressed unified memory. It turns byte, halfword and word loads and stores into word-aligned memory cycles. Sub-word stores use a read-modify-write sequence. It also checks alignment and returns sign- or zero-extended load data. One request is in flight at a time; the controller holds off with `req_ready`.

## Interface
- `XLEN`, 32, data/address width; only 32 supported.
- `clk  in  1  rising-edge clock`
- `reset  in  1  synchronous, active-high reset`
- `req_valid  in  1  request present`
- `req_ready  out  1  unit idle, request accepted on valid&ready edge`
- `req_we  in  1  1 = store, 0 = load`
- `req_funct3  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu`
- `req_addr  in  XLEN  byte address`
- `req_wdata  in  XLEN  store data, right-justified`
- `resp_valid  out  1  one-cycle completion pulse`
- `resp_rdata  out  XLEN  extended load data; 0 for stores and errors`
- `resp_err  out  1  access rejected, no memory write performed`
- `mem_we  out  1  memory write enable`
- `mem_a  out  XLEN  memory byte address, bits [1:0] always 0`
- `mem_wd  out  XLEN  memory write word`
- `mem_rd  in  XLEN  memory read word, combinational from mem_a`

## Operation
- The request is latched at accept into `addr_q`, `wdata_q`, `f3_q` and `we_q`.
- `mem_a = {addr_q[31:2], 2'b00}` in every non-IDLE state, and 0 in IDLE.
- States:
  - IDLE: `req_ready=1`. On accept, go to ERR if the request is illegal, otherwise to ACCESS.
  - ACCESS, load: extract the lane from `mem_rd` into `rdata_q`, then go to DONE.
  - ACCESS, word store: `mem_we=1`, `mem_wd=wdata_q`, then go to DONE.
  - ACCESS, sub-word store: capture `mem_rd` into `merge_q`, then go to WRITE.
  - WRITE: `mem_we=1`, `mem_wd` = `merge_q` with the selected byte lane (`addr_q[1:0]`) or halfword lane (`addr_q[1]`) replaced by `wdata_q[7:0]` or `wdata_q[15:0]`. Then go to DONE.
  - DONE: `resp_valid=1`, `resp_err=0`. Then go to IDLE.
  - ERR: `resp_valid=1`, `resp_err=1`, `resp_rdata=0`, no memory access. Then go to IDLE.
- Load extraction:
  - b and h sign-extend from bit 7 or bit 15 of the selected lane.
  - bu and hu zero-extend.
  - w passes the word through.
- Illegal requests:
  - funct3 011, 110 or 111 is always illegal, for both loads and stores.
  - A store with funct3 100 or 101 is illegal.
  - Misalignment is illegal only when the macro in Configuration is defined.
- `resp_rdata` is held from `rdata_q` and is valid only while `resp_valid=1`. It is 0 for stores.

## Timing
- Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `mem_we=0`, `mem_a=0`, `mem_wd=0`, all internal registers 0.
- `mem_we` is gated by `reset`: it is 0 in any cycle where `reset=1`. A reset in WRITE or ACCESS therefore never writes memory.
- Latency is counted from the accept edge (cycle 0) to the cycle in which `resp_valid` is high:
  - load and word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Back-to-back: the next request can be accepted in the cycle after DONE or ERR, because `req_ready` is high again in IDLE.
- `req_*` inputs are ignored when `req_ready=0`. Holding `req_valid` during a busy period has no effect.
- The RMW read and write target the same word in consecutive cycles. The memory is exclusively owned by this unit while it is busy.

## Configuration
- `LSU_MISALIGN_TRAP_EN`:
  - Defined: a halfword with `addr[0]=1`, or a word with `addr[1:0]!=0`, goes to ERR with no access.
  - Undefined: the ignored low bits are masked. Halfword lane select uses `addr[1]` only; words ignore `addr[1:0]`. The access proceeds normally and `resp_err` is raised only for illegal funct3.

## Structure
- `lsu_pkg` contains:
  - the state enum `lsu_state_t` (IDLE, ACCESS, WRITE, DONE, ERR);
  - funct3 localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
- One combinational sub-module, `lsu_lane_align`, takes the word, address low bits, funct3 and store data. It produces both the extended load value and the merged store word.
- The FSM, latches and handshake stay in `mem_lsu`.

## Test plan
- Memory word 0x0 = 0x8899AABB:
  - lb @0x2 → `resp_rdata` 0xFFFFFF99;
  - lbu @0x2 → 0x00000099;
  - lhu @0x2 → 0x00008899;
  - each has `resp_valid` 2 cycles after accept.
- sb 0x55 @0x1 over 0x8899AABB → exactly one `mem_we` pulse, in WRITE, with `mem_wd` 0x889955BB. `resp_valid` is high 3 cycles after accept.
- sw 0xDEADBEEF @0x8, then lw @0x8 back-to-back → 0xDEADBEEF. Second accept occurs the cycle after the first DONE.
- With the macro defined, lh @0x3 → `resp_err=1` and `resp_rdata=0` 1 cycle after accept, with no `mem_we`. Without the macro, the same request returns the sign-extended halfword at lane 1.
- sbu (store, funct3 100) → `resp_err=1` and memory unchanged. funct3 111 load → `resp_err=1`.
- Assert `reset` while in WRITE of sh 0x1234 @0x0 → `mem_we=0` that cycle, memory word unchanged, then IDLE with all outputs at reset values.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the load/store unit.
// LSU_MISALIGN_TRAP_EN selects whether misaligned halfword/word accesses trap.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCESS = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_ERR    = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    WRITE  = ST_WRITE,
    DONE   = ST_DONE,
    ERR    = ST_ERR
  } lsu_state_t;

  // Width codes without a meaning, and unsigned stores, are rejected.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    logic bad;
    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if (we && ((f3 == F3_BU) || (f3 == F3_HU))) bad = 1'b1;
    return bad;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (((f3 == F3_H) || (f3 == F3_HU)) && lo[0]) bad = 1'b1;
    if ((f3 == F3_W) && (lo != 2'b00))            bad = 1'b1;
    return bad;
  endfunction
`endif

endpackage

// File: rtl/mem_lsu_if.sv
// Request/response handshake between the datapath controller and the LSU.
interface mem_lsu_if;

  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [lsu_pkg::XLEN-1:0] req_addr;
  logic [lsu_pkg::XLEN-1:0] req_wdata;
  logic                     resp_valid;
  logic [lsu_pkg::XLEN-1:0] resp_rdata;
  logic                     resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_lsu_lane_align.sv
// Byte/halfword lane handling: extended load value and merged store word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] word_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] load_o,
  output logic [XLEN-1:0] merge_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word_i[{addr_lo_i, 3'b000} +: 8];
    half_lane = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    load_o = word_i;
    case (funct3_i)
      F3_B:    load_o = {{24{byte_lane[7]}}, byte_lane};
      F3_BU:   load_o = {24'h000000, byte_lane};
      F3_H:    load_o = {{16{half_lane[15]}}, half_lane};
      F3_HU:   load_o = {16'h0000, half_lane};
      default: load_o = word_i;
    endcase
  end

  always_comb begin
    merge_o = word_i;
    case (funct3_i)
      F3_B, F3_BU: merge_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      F3_H, F3_HU: begin
        if (addr_lo_i[1]) merge_o[31:16] = wdata_i[15:0];
        else              merge_o[15:0]  = wdata_i[15:0];
      end
      default:     merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: one request at a time, read-modify-write for sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module mem_lsu
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mem_lsu_if.slave        bus,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  lsu_state_t      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      f3_q, f3_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [XLEN-1:0] merge_q, merge_d;

  logic            accept;
  logic            req_bad;
  logic            word_store;
  logic [XLEN-1:0] align_word;
  logic [XLEN-1:0] load_ext;
  logic [XLEN-1:0] merged;

  assign accept     = bus.req_valid && (state_q == IDLE);
  assign word_store = we_q && (f3_q == F3_W);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_bad = f3_illegal(bus.req_we, bus.req_funct3) ||
                   misaligned(bus.req_funct3, bus.req_addr[1:0]);
`else
  assign req_bad = f3_illegal(bus.req_we, bus.req_funct3);
`endif

  // One aligner serves both phases: memory word in ACCESS, saved word in WRITE.
  assign align_word = (state_q == WRITE) ? merge_q : mem_rd;

  lsu_lane_align u_align (
    .word_i    (align_word),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (f3_q),
    .wdata_i   (wdata_q),
    .load_o    (load_ext),
    .merge_o   (merged)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          f3_d    = bus.req_funct3;
          we_d    = bus.req_we;
          rdata_d = '0;
          state_d = req_bad ? ERR : ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = load_ext;
          state_d = DONE;
        end else if (word_store) begin
          rdata_d = '0;
          state_d = DONE;
        end else begin
          rdata_d = '0;
          merge_d = mem_rd;
          state_d = WRITE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
    end
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == DONE) || (state_q == ERR);
    bus.resp_err   = (state_q == ERR);
    bus.resp_rdata = rdata_q;
  end

  always_comb begin
    mem_a  = (state_q == IDLE) ? '0 : {addr_q[XLEN-1:2], 2'b00};
    mem_wd = '0;
    mem_we = 1'b0;
    if ((state_q == ACCESS) && word_store) begin
      mem_we = 1'b1;
      mem_wd = wdata_q;
    end else if (state_q == WRITE) begin
      mem_we = 1'b1;
      mem_wd = merged;
    end
    // Reset must suppress a write already in progress.
    if (reset) mem_we = 1'b0;
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized self-checking bench for mem_lsu against a word-array reference model.
module tb_mem_lsu;

  logic        clk;
  logic        reset;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] tb_mem  [64];
  logic [31:0] ref_mem [64];

  int n_checks;
  int n_pass;

  logic [31:0] last_rdata;
  logic [31:0] last_wd;
  logic        last_err;
  int          last_lat;
  int          last_waits;

  mem_lsu_if bus ();

  mem_lsu dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rd = tb_mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_a[7:2]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic model_illegal(input logic we, input logic [2:0] f3, input logic [7:0] a);
    logic bad;
    bad = (f3 == 3) || (f3 >= 6) || (we && (f3 == 4 || f3 == 5));
`ifdef LSU_MISALIGN_TRAP_EN
    if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) bad = 1'b1;
    if (f3 == 2 && (a % 4 != 0))               bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [7:0] a, input logic [2:0] f3);
    int unsigned bsh, hsh;
    logic [31:0] v;
    bsh = 8 * (a % 4);
    hsh = 16 * ((a / 2) % 2);
    case (f3)
      0: begin v = (w >> bsh) & 32'hFF;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      4: v = (w >> bsh) & 32'hFF;
      1: begin v = (w >> hsh) & 32'hFFFF; if (v >= 32768) v = v + 32'hFFFF_0000; end
      5: v = (w >> hsh) & 32'hFFFF;
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [7:0] a,
                                              input logic [2:0] f3, input logic [31:0] d);
    int unsigned sh;
    logic [31:0] mask;
    if (f3 == 2) return d;
    if (f3 == 0) begin
      sh = 8 * (a % 4);
      mask = 32'hFF << sh;
    end else begin
      sh = 16 * ((a / 2) % 2);
      mask = 32'hFFFF << sh;
    end
    return (w & ~mask) | ((d << sh) & mask);
  endfunction

  // Issue one request from a negedge, check the whole transaction, return at the response negedge.
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    logic [7:0]  a;
    logic        exp_err;
    logic [31:0] exp_rdata, exp_wd;
    int          exp_lat, exp_pulses, pulses;
    bit          got;
    a = addr[7:0];
    exp_err    = model_illegal(we, f3, a);
    exp_rdata  = 32'h0;
    exp_wd     = 32'h0;
    exp_pulses = 0;
    if (exp_err) exp_lat = 1;
    else if (we && f3 != 2) exp_lat = 3;
    else exp_lat = 2;
    if (!exp_err && !we) exp_rdata = model_load(ref_mem[a[7:2]], a, f3);
    if (!exp_err && we) begin
      exp_pulses = 1;
      exp_wd = model_store(ref_mem[a[7:2]], a, f3, wd);
      ref_mem[a[7:2]] = exp_wd;
    end

    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    last_waits = 0;
    while (!bus.req_ready && last_waits < 10) begin
      @(negedge clk);
      last_waits++;
    end
    if (!bus.req_ready) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.req_we     = $urandom_range(0, 1);
    bus.req_funct3 = $urandom_range(0, 7);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;

    pulses = 0;
    got = 1'b0;
    last_lat = 0;
    last_wd = 32'h0;
    for (int k = 1; k <= 8 && !got; k++) begin
      @(negedge clk);
      if (k == 1) check("mem_a", mem_a, {addr[31:2], 2'b00});
      if (mem_we) begin
        pulses++;
        last_wd = mem_wd;
        check("mem_wd", mem_wd, exp_wd);
      end
      if (bus.resp_valid) begin
        got = 1'b1;
        last_lat   = k;
        last_rdata = bus.resp_rdata;
        last_err   = bus.resp_err;
        bus.req_valid = 1'b0;
        check("resp_rdata", bus.resp_rdata, exp_rdata);
        check("resp_err", {31'd0, bus.resp_err}, {31'd0, exp_err});
      end
    end
    bus.req_valid = 1'b0;
    if (!got) check("resp_timeout", 32'd0, 32'd1);
    check("latency", last_lat, exp_lat);
    check("we_pulses", pulses, exp_pulses);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"},  {31'd0, bus.req_ready},  32'd1);
    check({tag, "_rvalid"}, {31'd0, bus.resp_valid}, 32'd0);
    check({tag, "_rerr"},   {31'd0, bus.resp_err},   32'd0);
    check({tag, "_rdata"},  bus.resp_rdata,          32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we},         32'd0);
    check({tag, "_mem_a"},  mem_a,                   32'd0);
    check({tag, "_mem_wd"}, mem_wd,                  32'd0);
  endtask

  initial begin
    logic [2:0] legal_f3 [5];
    logic [2:0] f3;
    n_checks = 0;
    n_pass   = 0;
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]  = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[0]  = 32'h8899_AABB;
    ref_mem[0] = 32'h8899_AABB;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    reset = 1'b0;
    @(negedge clk);

    run(1'b0, 3'd0, 32'h2, 32'h0);
    check("lb_val", last_rdata, 32'hFFFF_FF99);
    run(1'b0, 3'd4, 32'h2, 32'h0);
    check("lbu_val", last_rdata, 32'h0000_0099);
    run(1'b0, 3'd5, 32'h2, 32'h0);
    check("lhu_val", last_rdata, 32'h0000_8899);
    check("lhu_lat", last_lat, 32'd2);
    run(1'b1, 3'd0, 32'h1, 32'h55);
    check("sb_wd", last_wd, 32'h8899_55BB);
    check("sb_lat", last_lat, 32'd3);
    run(1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF);
    run(1'b0, 3'd2, 32'h8, 32'h0);
    check("b2b_waits", last_waits, 32'd1);
    check("lw_val", last_rdata, 32'hDEAD_BEEF);
    run(1'b0, 3'd1, 32'h3, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lh3_err", {31'd0, last_err}, 32'd1);
    check("lh3_lat", last_lat, 32'd1);
`else
    check("lh3_val", last_rdata, 32'hFFFF_8899);
`endif
    run(1'b1, 3'd4, 32'h10, 32'h1234_5678);
    check("sbu_err", {31'd0, last_err}, 32'd1);
    run(1'b0, 3'd7, 32'h14, 32'h0);
    check("f3_7_err", {31'd0, last_err}, 32'd1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 8) f3 = legal_f3[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 7));
      run(1'($urandom_range(0, 1)), f3, {$urandom_range(0, 15), 20'h0, 8'($urandom)}, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    // Reset during WRITE of sh 0x1234 @0x0 must not touch memory.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd1;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h1234;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("write_state_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1 check("rst_write_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 check_idle_outputs("rstw");
    check("rstw_mem0", tb_mem[0], ref_mem[0]);

    for (int i = 0; i < 64; i++) check("mem_final", tb_mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
